reg_dump_reader: RTL and testbench

- Debug read-out engine that sits on the register file's SR1 read port and streams register contents out through a valid/ready interface.
- Typical sinks are the hex-display driver or a serial debug port.
- It is the consumer of what the register file stores: it walks a programmable subset of R0–R7 and emits one (index, value) pair per selected register.
- It is used only while the CPU datapath is halted or paused; the SR1 select mux in the top level hands SR1 to this block when BUSY is high.

---
 rtl/reg_dump_reader.sv | 146 ++++++++++++++
 tb/tb_reg_dump_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks the selected registers over the SR1 read port
// and streams (index, value) pairs out through a valid/ready interface.
`timescale 1ns/1ps
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned WIDTH    = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                START,
  input  logic [NUM_REGS-1:0] MASK,
  input  logic                ABORT,
  output logic [IDX_W-1:0]    SR_SEL,
  input  logic [WIDTH-1:0]    SR_DATA,
  output logic [WIDTH-1:0]    DOUT,
  output logic [IDX_W-1:0]    DOUT_IDX,
  output logic                DOUT_VALID,
  input  logic                DOUT_READY,
  output logic                BUSY,
  output logic                DONE
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    sr_sel_q, sr_sel_d;
  logic [IDX_W-1:0]    dout_idx_q, dout_idx_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDX_W:0]      first_hit, next_hit;

  // Returns {found, index} of the lowest set bit of m at or above position lo;
  // the search stops at NUM_REGS-1, so a dump never wraps back to R0.
  function automatic logic [IDX_W:0] find_set(input logic [NUM_REGS-1:0] m,
                                               input int unsigned lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!r[IDX_W] && (i >= lo) && m[i]) begin
        r = {1'b1, IDX_W'(i)};
      end
    end
    return r;
  endfunction

  assign first_hit = find_set(MASK, 32'd0);
  assign next_hit  = find_set(mask_q, 32'(idx_q) + 32'd1);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    dout_d     = dout_q;
    dout_idx_d = dout_idx_q;

    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          mask_d = MASK;
          if (first_hit[IDX_W]) begin
            idx_d   = first_hit[IDX_W-1:0];
            state_d = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        dout_d     = SR_DATA;
        dout_idx_d = idx_q;
        state_d    = SEND;
      end
      SEND: begin
        if (dout_valid_q && DOUT_READY) begin
          if (next_hit[IDX_W]) begin
            idx_d   = next_hit[IDX_W-1:0];
            state_d = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything once a dump is running; the output word keeps
    // its previous value rather than capturing an unfinished fetch.
    if (ABORT && (state_q != IDLE)) begin
      state_d    = IDLE;
      dout_d     = dout_q;
      dout_idx_d = dout_idx_q;
    end

    busy_d       = (state_d != IDLE);
    dout_valid_d = (state_d == SEND);
    done_d       = (state_d == FIN);
    sr_sel_d     = ((state_d == FETCH) || (state_d == SEND)) ? idx_d : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      idx_q        <= '0;
      sr_sel_q     <= '0;
      dout_q       <= '0;
      dout_idx_q   <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      sr_sel_q     <= sr_sel_d;
      dout_q       <= dout_d;
      dout_idx_q   <= dout_idx_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign SR_SEL     = sr_sel_q;
  assign DOUT       = dout_q;
  assign DOUT_IDX   = dout_idx_q;
  assign DOUT_VALID = dout_valid_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a register-file model feeds SR_DATA,
// dumps push expected words into a queue and a negedge monitor pops them.
`timescale 1ns/1ps
module tb_reg_dump_reader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        DOUT_READY = 1'b0;
  logic [7:0]  MASK = '0;
  logic [2:0]  SR_SEL, DOUT_IDX;
  logic [15:0] SR_DATA, DOUT;
  logic        DOUT_VALID, BUSY, DONE;

  logic [15:0] regs [8];
  assign SR_DATA = regs[SR_SEL];

  always #5 Clk = ~Clk;

  reg_dump_reader #(.NUM_REGS(8), .IDX_W(3), .WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .START(START), .MASK(MASK), .ABORT(ABORT),
    .SR_SEL(SR_SEL), .SR_DATA(SR_DATA), .DOUT(DOUT), .DOUT_IDX(DOUT_IDX),
    .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .BUSY(BUSY), .DONE(DONE)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_done;
    logic [2:0]  idx;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: one word per set mask bit in ascending order, values as
  // the register file holds them now, followed by a single DONE.
  task automatic start_dump(input logic [7:0] m);
    START = 1'b1;
    MASK  = m;
    for (int i = 0; i < 8; i++)
      if (m[i]) sb.push_back('{1'b0, 3'(i), regs[i]});
    sb.push_back('{1'b1, 3'd0, 16'd0});
    step();
    START = 1'b0;
    MASK  = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int n = 0;
    while (BUSY && n < budget) begin
      if (rand_ready) DOUT_READY = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, BUSY}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_sr_sel"}, SR_SEL, 0);
    chk({tag, "_dout"}, DOUT, 0);
    chk({tag, "_dout_idx"}, DOUT_IDX, 0);
    chk({tag, "_valid"}, DOUT_VALID, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
  endtask

  // Monitor
  logic        pv = 1'b0, pr = 1'b0, pa = 1'b0;
  logic [15:0] pd = '0;
  logic [2:0]  pi = '0;
  exp_t        e;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (pv && !pr && !pa) begin
        chk("hold_valid", DOUT_VALID, 1);
        chk("hold_dout", DOUT, pd);
        chk("hold_idx", DOUT_IDX, pi);
      end
      if (DONE) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got DONE expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("done_order", e.is_done, 1);
        end
      end
      if (DOUT_VALID && DOUT_READY) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_unexpected: got idx %0d data %0h expected none at %0t",
                   DOUT_IDX, DOUT, $time);
        end else begin
          e = sb.pop_front();
          chk("word_kind", e.is_done, 0);
          chk("word_idx", DOUT_IDX, e.idx);
          chk("word_data", DOUT, e.data);
        end
      end
    end
    pv = DOUT_VALID && !Reset;
    pr = DOUT_READY;
    pa = ABORT;
    pd = DOUT;
    pi = DOUT_IDX;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);

    // Reset state
    #1 Reset = 1'b1;
    #1 chk_outputs_zero("reset");
    step();
    step();
    Reset = 1'b0;
    step();

    // Full dump with exact cycle timing
    DOUT_READY = 1'b1;
    start_dump(8'hFF);
    for (int k = 1; k <= 18; k++) begin
      chk("full_valid", DOUT_VALID, (k >= 2 && k <= 16 && k % 2 == 0) ? 1 : 0);
      chk("full_done", DONE, (k == 17) ? 1 : 0);
      chk("full_busy", BUSY, (k <= 17) ? 1 : 0);
      if (k % 2 == 1 && k <= 15) chk("full_sr_sel", SR_SEL, (k - 1) / 2);
      step();
    end
    chk("full_sb", sb.size(), 0);

    // Sparse mask with a START pulse ignored mid-dump
    start_dump(8'b1010_0100);
    step();
    START = 1'b1;
    MASK  = 8'hFF;
    step();
    START = 1'b0;
    wait_idle(40, 1'b0);

    // Empty mask; START during FIN is ignored
    start_dump(8'h00);
    chk("empty_done", DONE, 1);
    chk("empty_busy", BUSY, 1);
    chk("empty_valid", DOUT_VALID, 0);
    START = 1'b1;
    MASK  = 8'hFF;
    step();
    START = 1'b0;
    chk("empty_done_off", DONE, 0);
    chk("empty_busy_off", BUSY, 0);
    step();
    chk("fin_start_ignored", BUSY, 0);
    chk("empty_sb", sb.size(), 0);

    // Backpressure on idx 3, with R3 rewritten during the stall
    start_dump(8'hFF);
    for (int n = 0; n < 40 && !(DOUT_VALID && DOUT_IDX == 3); n++) step();
    chk("bp_reached", {29'd0, DOUT_IDX}, 3);
    DOUT_READY = 1'b0;
    regs[3] = 16'hBEEF;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_valid", DOUT_VALID, 1);
      chk("bp_dout", DOUT, 16'h1003);
      chk("bp_idx", DOUT_IDX, 3);
    end
    DOUT_READY = 1'b1;
    step();
    step();
    chk("bp_next_valid", DOUT_VALID, 1);
    chk("bp_next_idx", DOUT_IDX, 4);
    wait_idle(40, 1'b0);

    // Abort during SEND of idx 4, then a restart
    start_dump(8'hFF);
    for (int n = 0; n < 40 && !(DOUT_VALID && DOUT_IDX == 4); n++) step();
    DOUT_READY = 1'b0;
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk("abort_valid", DOUT_VALID, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_pending", sb.size(), 5);
    if (sb.size() > 0) chk("abort_head_idx", sb[0].idx, 4);
    sb.delete();
    step();
    chk("abort_no_done", DONE, 0);
    DOUT_READY = 1'b1;
    start_dump(8'h01);
    wait_idle(20, 1'b0);

    // ABORT in IDLE takes priority over START
    START = 1'b1;
    ABORT = 1'b1;
    MASK  = 8'hFF;
    step();
    START = 1'b0;
    ABORT = 1'b0;
    chk("idle_abort_busy", BUSY, 0);
    step();
    chk("idle_abort_busy2", BUSY, 0);

    // Asynchronous reset mid-dump
    DOUT_READY = 1'b1;
    start_dump(8'hFF);
    step();
    step();
    chk("pre_reset_sr_sel", SR_SEL, 1);
    #3 Reset = 1'b1;
    #1 chk_outputs_zero("async_reset");
    sb.delete();
    step();
    Reset = 1'b0;
    step();
    chk("post_reset_busy", BUSY, 0);

    // Randomized dumps under random backpressure
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      DOUT_READY = ($urandom_range(0, 1) != 0);
      start_dump(8'($urandom));
      wait_idle(120, 1'b1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
